// File: rtl/conv_encoder_stream.sv
// Rate-1/2 convolutional encoder with valid/ready word streaming and optional zero-tail termination.
// Each data word is encoded MSB first, one bit per clock. Encoder state carries across words.
module conv_encoder_stream #(
  parameter int             DATA_W = 4,
  parameter int             K      = 3,
  parameter logic [K-1:0]   G0     = 3'b111,
  parameter logic [K-1:0]   G1     = 3'b101
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                term_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_last,
  output logic                out_tail,
  output logic [K-2:0]        enc_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The producer holds valid and its payload steady until that edge; ready may not depend on valid.

  localparam int OUT_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL_BIT = CNT_W'(K - 2);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENC  = 3'd1,
    ST_OUT  = 3'd2,
    ST_TAIL = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [K-2:0]       sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               last_q, last_d;
  logic               term_q, term_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;

  logic               u;
  logic [K-1:0]       w;
  logic               c0, c1;
  logic [OUT_W-1:0]   pair_w;

  // Tail bits are zeros; data bits come from the MSB of the shifting word.
  assign u      = (state_q == ST_ENC) ? data_q[DATA_W-1] : 1'b0;
  assign w      = {u, sr_q};
  assign c0     = ^(G0 & w);
  assign c1     = ^(G1 & w);
  assign pair_w = {c0, c1, {(OUT_W-2){1'b0}}} >> {cnt_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    term_d     = term_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          last_d     = in_last;
          term_d     = term_en;
          cnt_d      = '0;
          out_data_d = '0;
          state_d    = ST_ENC;
        end
      end
      ST_ENC: begin
        sr_d       = w[K-1:1];
        data_d     = {data_q[DATA_W-2:0], 1'b0};
        out_data_d = out_data_q | pair_w;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_DATA_BIT) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (last_q && term_q) begin
            out_data_d = '0;
            cnt_d      = '0;
            state_d    = ST_TAIL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TAIL: begin
        sr_d       = w[K-1:1];
        out_data_d = out_data_q | pair_w;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_TAIL_BIT) begin
          cnt_d   = '0;
          state_d = ST_TOUT;
        end
      end
      ST_TOUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any handshake seen in the same cycle.
    if (clr) begin
      state_d    = ST_IDLE;
      sr_d       = '0;
      cnt_d      = '0;
      out_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      term_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      term_q     <= term_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT) || (state_q == ST_TOUT);
  assign out_last  = ((state_q == ST_OUT) && last_q && !term_q) || (state_q == ST_TOUT);
  assign out_tail  = (state_q == ST_TOUT);
  assign out_data  = out_data_q;
  assign enc_state = sr_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed vector table plus corner-case sequences for the default encoder, and random
// frames on a DATA_W=8 / K=7 instance checked against a bit-serial reference.
module tb_conv_encoder_stream;

  localparam int W  = 4;
  localparam int KA = 3;
  localparam int BW = 8;
  localparam int BK = 7;
  localparam logic [6:0] BG0 = 7'o171;
  localparam logic [6:0] BG1 = 7'o133;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clr, term_en, in_valid, in_last, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_last, out_tail;
  logic [2*W-1:0] out_data;
  logic [KA-2:0]  enc_state;

  logic          b_clr, b_term_en, b_in_valid, b_in_last, b_out_ready;
  logic [BW-1:0] b_in_data;
  logic          b_in_ready, b_out_valid, b_out_last, b_out_tail;
  logic [2*BW-1:0] b_out_data;
  logic [BK-2:0]   b_enc_state;

  conv_encoder_stream dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .term_en(term_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_tail(out_tail), .enc_state(enc_state)
  );

  conv_encoder_stream #(.DATA_W(BW), .K(BK), .G0(BG0), .G1(BG1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .term_en(b_term_en),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_tail(b_out_tail), .enc_state(b_enc_state)
  );

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  typedef struct {
    logic [3:0] d;
    logic       l;
    logic       t;
    logic [7:0] exp_w;
    logic [1:0] exp_sr;
    logic [7:0] exp_tail;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driver tasks start and end on a falling edge.
  task automatic send_a(input logic [3:0] d, input logic l, input logic t);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("a_in_ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = d; in_last = l; term_en = t;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; term_en = 1'b0;
  endtask

  task automatic wait_out_a(input string name, input int lat);
    int n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({name, "_latency"}, n, lat);
  endtask

  task automatic accept_a();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l, input logic t);
    int n = 0;
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_in_ready) check("b_in_ready_timeout", 0, 1);
    b_in_valid = 1'b1; b_in_data = d; b_in_last = l; b_term_en = t;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_term_en = 1'b0;
  endtask

  task automatic wait_out_b(input string name, input int lat);
    int n = 0;
    while (!b_out_valid && n < 40) begin @(negedge clk); n++; end
    check({name, "_latency"}, n, lat);
  endtask

  task automatic model_enc(input logic [7:0] d, input int nbits, input logic [5:0] sr_in,
                           output logic [15:0] cw, output logic [5:0] sr_out);
    logic [6:0] w;
    logic [5:0] s;
    s  = sr_in;
    cw = '0;
    for (int i = 0; i < nbits; i++) begin
      w = {d[7-i], s};
      cw[15-2*i] = ^(w & BG0);
      cw[14-2*i] = ^(w & BG1);
      s = w[6:1];
    end
    sr_out = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [5:0]  m_sr;
    logic [15:0] cw;
    logic [17:0] e;
    int nwords;
    logic term;
    logic [7:0] d8;

    vecs[0] = '{4'b0101, 1'b0, 1'b0, 8'h38, 2'b10, 8'h00};
    vecs[1] = '{4'b1010, 1'b0, 1'b0, 8'h52, 2'b01, 8'h00};
    vecs[2] = '{4'b1010, 1'b1, 1'b1, 8'h22, 2'b01, 8'hC0};
    vecs[3] = '{4'b1010, 1'b1, 1'b1, 8'hE2, 2'b01, 8'hC0};
    vecs[4] = '{4'b1111, 1'b1, 1'b0, 8'hDA, 2'b11, 8'h00};
    vecs[5] = '{4'b0000, 1'b1, 1'b1, 8'h70, 2'b00, 8'h00};
    vecs[6] = '{4'b1000, 1'b0, 1'b0, 8'hEC, 2'b00, 8'h00};

    rst_n = 1'b0; clr = 1'b0; term_en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b0;
    b_clr = 1'b0; b_term_en = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0;
    b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_tail", out_tail, 0);
    check("rst_enc_state", enc_state, 0);

    for (int i = 0; i < 7; i++) begin
      send_a(vecs[i].d, vecs[i].l, vecs[i].t);
      wait_out_a("vec_word", W);
      check("vec_out_data", out_data, vecs[i].exp_w);
      check("vec_out_last", out_last, vecs[i].l & ~vecs[i].t);
      check("vec_out_tail", out_tail, 0);
      check("vec_enc_state", enc_state, vecs[i].exp_sr);
      accept_a();
      if (vecs[i].l && vecs[i].t) begin
        check("vec_in_ready_in_tail", in_ready, 0);
        wait_out_a("vec_tail", KA - 1);
        check("vec_tail_data", out_data, vecs[i].exp_tail);
        check("vec_tail_flag", out_tail, 1);
        check("vec_tail_last", out_last, 1);
        accept_a();
        check("vec_sr_after_tail", enc_state, 0);
      end
      check("vec_in_ready_after", in_ready, 1);
    end

    // Backpressure in OUT: word, flags and encoder state must hold.
    send_a(4'b1010, 1'b0, 1'b0);
    wait_out_a("bp_word", W);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 8'hE2);
      check("bp_in_ready", in_ready, 0);
      check("bp_enc_state", enc_state, 2'b01);
      @(negedge clk);
    end
    accept_a();

    // clr mid-ENC drops the word and zeroes the encoder.
    send_a(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_in_ready", in_ready, 1);
    check("clr_enc_state", enc_state, 0);
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("clr_no_out_valid", seen, 0);
    send_a(4'b1010, 1'b1, 1'b0);
    wait_out_a("clr_next_word", W);
    check("clr_next_data", out_data, 8'hE2);
    check("clr_next_last", out_last, 1);
    accept_a();

    // clr together with out_ready on a terminated word: no tail follows.
    send_a(4'b0000, 1'b1, 1'b1);
    wait_out_a("clr_out_word", W);
    check("clr_out_data", out_data, 8'hC0);
    out_ready = 1'b1; clr = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; clr = 1'b0;
    check("clr_out_in_ready", in_ready, 1);
    check("clr_out_valid", out_valid, 0);
    check("clr_out_enc_state", enc_state, 0);
    seen = 1'b0;
    for (int i = 0; i < KA + 2; i++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("clr_out_no_tail", seen, 0);

    // Asynchronous reset while the tail is being built.
    send_a(4'b1010, 1'b1, 1'b1);
    wait_out_a("rst_tail_word", W);
    check("rst_tail_word_data", out_data, 8'hE2);
    accept_a();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_out_last", out_last, 0);
    check("rst_mid_out_tail", out_tail, 0);
    check("rst_mid_enc_state", enc_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < KA + 4; i++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("rst_mid_no_tail", seen, 0);

    // Random frames on the wide instance against the bit-serial reference.
    m_sr = '0;
    for (int f = 0; f < 14; f++) begin
      nwords = $urandom_range(1, 3);
      term   = 1'($urandom_range(0, 1));
      for (int j = 0; j < nwords; j++) begin
        d8 = 8'($urandom_range(0, 255));
        model_enc(d8, BW, m_sr, cw, m_sr);
        exp_q.push_back({1'b0, (j == nwords - 1) & ~term, cw});
        send_b(d8, j == nwords - 1, term);
        wait_out_b("b_word", BW);
        e = exp_q.pop_front();
        check("b_word_data", b_out_data, e[15:0]);
        check("b_word_last", b_out_last, e[16]);
        check("b_word_tail", b_out_tail, e[17]);
        check("b_word_state", b_enc_state, m_sr);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("b_word_hold", b_out_data, e[15:0]);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        if (j == nwords - 1 && term) begin
          model_enc(8'h00, BK - 1, m_sr, cw, m_sr);
          exp_q.push_back({1'b1, 1'b1, cw});
          wait_out_b("b_tail", BK - 1);
          e = exp_q.pop_front();
          check("b_tail_data", b_out_data, e[15:0]);
          check("b_tail_last", b_out_last, e[16]);
          check("b_tail_flag", b_out_tail, e[17]);
          b_out_ready = 1'b1;
          @(negedge clk);
          b_out_ready = 1'b0;
          check("b_tail_state", b_enc_state, m_sr);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder_stream.md
# conv_encoder_stream

Parametrised, handshaked rate-1/2 convolutional encoder for the encoding/decoding datapath. Accepts DATA_W-bit data words, encodes them serially (one bit per clock, MSB first) with two generator polynomials of constraint length K, and emits 2·DATA_W-bit coded words. Encoder state carries across words within a frame. An optional zero-tail termination flushes the encoder at frame end and emits a separate tail word.

## Interface
- DATA_W, 4: data word width; legal range 2..32.
- K, 3: constraint length; legal range 3..7, with K-1 ≤ DATA_W.
- G0, 3'b111: generator 0, K bits; MSB taps the current input bit.
- G1, 3'b101: generator 1, K bits; MSB taps the current input bit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort: to IDLE, encoder state zeroed, out_valid dropped.
- term_en  in  1  1 = zero-tail termination on in_last; sampled with the accepted word.
- in_valid  in  1  input word valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  DATA_W  data word, MSB encoded first.
- in_last  in  1  word closes the frame.
- out_valid  out  1  coded word valid; held until accepted.
- out_ready  in  1  downstream accept.
- out_data  out  2·DATA_W  coded word.
- out_last  out  1  final word of the frame.
- out_tail  out  1  out_data is a tail word.
- enc_state  out  K-1  current shift-register contents.

## Operation
- Shift register sr[K-2:0] holds previous input bits; sr[K-2] is the newest.
- For input bit u, the window is w = {u, sr}.
  - c0 = XOR of (G0 & w); c1 = XOR of (G1 & w).
  - Next sr = w[K-1:1].
- Packing: for the i-th processed bit (i=0 is the MSB of the word), c0 goes to out_data[2·DATA_W-1-2i] and c1 goes to out_data[2·DATA_W-2-2i].
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_data, in_last and term_en, then go to ENC with bit count 0.
  - ENC: process one bit per clock. After DATA_W bits, go to OUT.
  - OUT: out_valid=1 with the coded word.
    - out_last = latched_last & ~latched_term.
    - On out_ready: if latched_last & latched_term, go to TAIL; otherwise go to IDLE.
  - TAIL: feed K-1 zero bits, one per clock, packed from the MSB exactly as data bits. Unused low bits of out_data are 0. Then go to TOUT.
  - TOUT: out_valid=1, out_tail=1, out_last=1. On out_ready, go to IDLE. sr is then all zero.
- Without termination, sr persists across words and frames. Only clr, a completed tail, or reset zero it.
- out_data, out_last and out_tail are stable while out_valid=1 and out_ready=0.
- clr has priority over every transition, including a simultaneous in_valid or out_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - State is IDLE and sr=0.
  - out_valid=0, out_data=0, out_last=0, out_tail=0.
  - in_ready=1 and enc_state=0.
- A reset mid-frame discards all work in progress. No partial word is emitted.
- Word acceptance is the edge with in_valid & in_ready. out_valid rises DATA_W clocks after that edge.
- Minimum spacing between accepted words is DATA_W+2 clocks. There is no overlap, so in_ready=0 in ENC, OUT, TAIL and TOUT.
- Tail word: out_valid rises K-1 clocks after the data word is accepted downstream.
- Backpressure only stretches OUT and TOUT. The encoder state does not advance while stalled.

## Test plan
- Reset, then term_en=1, in_data=4'b1010, in_last=1, out_ready=1. Required: out_data=8'hE2 with out_last=0, then a tail word 8'hC0 with out_tail=1 and out_last=1; enc_state=0 afterwards.
- After reset, in_data=4'b0101, in_last=0. Required: out_data=8'h38 and enc_state=2'b10. A following word 4'b1010 with no termination encodes from sr=10.
- Backpressure: hold out_ready=0 for 5 clocks in OUT. Required: out_data is held at 8'hE2, in_ready=0, and enc_state is unchanged.
- clr asserted mid-ENC. Required: the next clock is IDLE, enc_state=0, out_valid never rises, and the next word 4'b1010 yields 8'hE2.
- rst_n pulsed low during TAIL. Required: all outputs immediately at reset values and no tail word emitted.
- Random frames at DATA_W=8, K=7, G0=7'o171, G1=7'o133, compared against a bit-serial reference model. Required: all words, tails and flags match.
